// File: rtl/mux_seq_n.sv
// Registered N:1 lane selector: captures an N-lane vector in one handshake and
// delivers lanes either streamed 0..N-1 or by random-access index.
//
// state  | meaning
// IDLE   | waiting for a vector; in_ready high
// STREAM | presenting lanes 0..N-1 in order, one per accepted beat
// ACCESS | serving indexed read requests until done
module mux_seq_n #(
    parameter int WIDTH = 16,
    parameter int N     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N*WIDTH-1:0]     in_data,
    input  logic                   mode,
    input  logic                   sel_valid,
    input  logic [$clog2(N)-1:0]   sel,
    input  logic                   done,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [$clog2(N)-1:0]   out_index,
    output logic                   out_last
);

    localparam int SEL_W = $clog2(N);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [N*WIDTH-1:0] buffer, buffer_d;
    logic               in_ready_d;
    logic               out_valid_d;
    logic [WIDTH-1:0]   out_data_d;
    logic [SEL_W-1:0]   out_index_d;
    logic               out_last_d;
    logic [SEL_W-1:0]   next_index;

    // Explicit compare per lane so indices >= N decode to zero.
    function automatic logic [WIDTH-1:0] pick(input logic [N*WIDTH-1:0] vec,
                                              input logic [SEL_W-1:0]   idx);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            if (idx == SEL_W'(k)) r = vec[k*WIDTH +: WIDTH];
        end
        return r;
    endfunction

    assign next_index = out_index + SEL_W'(1);
    assign in_ready_d = (state_d == IDLE);

    always_comb begin
        state_d     = state;
        buffer_d    = buffer;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        out_index_d = out_index;
        out_last_d  = out_last;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    buffer_d = in_data;
                    if (!mode) begin
                        state_d     = STREAM;
                        out_valid_d = 1'b1;
                        out_data_d  = in_data[WIDTH-1:0];
                        out_index_d = '0;
                        out_last_d  = 1'b0;
                    end else begin
                        state_d     = ACCESS;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end
                end
            end
            STREAM: begin
                if (out_valid && out_ready) begin
                    if (out_last) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        out_index_d = next_index;
                        out_data_d  = pick(buffer, next_index);
                        out_last_d  = (next_index == SEL_W'(N-1));
                    end
                end
            end
            ACCESS: begin
                // done has priority and drops any undelivered beat
                if (done) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    if (out_valid && out_ready) out_valid_d = 1'b0;
                    if (sel_valid && (!out_valid || out_ready)) begin
                        out_valid_d = 1'b1;
                        out_index_d = sel;
                        out_data_d  = pick(buffer, sel);
                        out_last_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buffer    <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
        end else begin
            buffer    <= buffer_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            out_index <= out_index_d;
            out_last  <= out_last_d;
        end
    end

endmodule

// File: tb/tb_mux_seq_n.sv
// Scoreboard bench for mux_seq_n: stimulus pushes expected beats, a negedge
// monitor pops and compares on every accepted output beat.
module tb_mux_seq_n;
    localparam int W  = 16;
    localparam int N  = 16;
    localparam int SW = 4;
    localparam int N2 = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic            in_valid, in_ready, mode, sel_valid, done;
    logic [N*W-1:0]  in_data;
    logic [SW-1:0]   sel, out_index;
    logic            out_valid, out_ready, out_last;
    logic [W-1:0]    out_data;

    logic            in_valid_b, in_ready_b, mode_b, sel_valid_b, done_b;
    logic [N2*W-1:0] in_data_b;
    logic [SW-1:0]   sel_b, out_index_b;
    logic            out_valid_b, out_ready_b, out_last_b;
    logic [W-1:0]    out_data_b;

    mux_seq_n #(.WIDTH(W), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .mode(mode), .sel_valid(sel_valid), .sel(sel),
        .done(done), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index), .out_last(out_last));

    mux_seq_n #(.WIDTH(W), .N(N2)) dut12 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_data(in_data_b), .mode(mode_b), .sel_valid(sel_valid_b), .sel(sel_b),
        .done(done_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_data(out_data_b), .out_index(out_index_b), .out_last(out_last_b));

    typedef struct packed {
        logic [W-1:0]  d;
        logic [SW-1:0] i;
        logic          l;
    } beat_t;

    beat_t exp_q[$];
    int    n_chk = 0;
    int    n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] lane_of(input logic [N*W-1:0] v, input int k);
        return v[k*W +: W];
    endfunction

    function automatic logic [N*W-1:0] rand_vec();
        logic [N*W-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = W'($urandom);
        return v;
    endfunction

    function automatic logic [N*W-1:0] ramp_vec();
        logic [N*W-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = W'(16'h0100 + k);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares each accepted beat and checks stability under stall.
    initial begin : monitor
        logic  stalled;
        beat_t held, e;
        stalled = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled && out_valid) begin
                    chk("hold_data", out_data, held.d);
                    chk("hold_index", out_index, held.i);
                    chk("hold_last", out_last, held.l);
                end
                if (out_valid && out_ready) begin
                    stalled = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got index %0d data %h, expected no beat",
                                 out_index, out_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", out_data, e.d);
                        chk("beat_index", out_index, e.i);
                        chk("beat_last", out_last, e.l);
                    end
                end else if (out_valid) begin
                    stalled = 1'b1;
                    held.d = out_data;
                    held.i = out_index;
                    held.l = out_last;
                end else begin
                    stalled = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready();
        int c;
        c = 0;
        while (!in_ready && c < 50) begin tick(); c++; end
        chk("in_ready_wait", in_ready, 1);
    endtask

    task automatic stream_capture(input logic [N*W-1:0] v);
        beat_t b;
        wait_ready();
        in_valid = 1'b1;
        in_data  = v;
        mode     = 1'b0;
        for (int k = 0; k < N; k++) begin
            b.d = lane_of(v, k);
            b.i = SW'(k);
            b.l = (k == N-1);
            exp_q.push_back(b);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic access_capture(input logic [N*W-1:0] v);
        wait_ready();
        in_valid = 1'b1;
        in_data  = v;
        mode     = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(output int cycles);
        cycles = 0;
        while (exp_q.size() != 0 && cycles < 2000) begin tick(); cycles++; end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin : stim
        logic [N*W-1:0]  va, vb;
        logic [N2*W-1:0] v12;
        beat_t           b;
        int              cyc;
        logic            pend, rdy, sv, taken;
        logic [SW-1:0]   s;

        in_valid = 0; in_data = '0; mode = 0; sel_valid = 0; sel = '0; done = 0; out_ready = 0;
        in_valid_b = 0; in_data_b = '0; mode_b = 0; sel_valid_b = 0; sel_b = '0; done_b = 0;
        out_ready_b = 0;

        #1 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_in_ready", in_ready, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        chk("rdy_at_release", in_ready, 0);
        tick();
        chk("rdy_after_release", in_ready, 1);

        // reset in the middle of a stream
        out_ready = 1'b1;
        stream_capture(rand_vec());
        repeat (5) tick();
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_out_last", out_last, 0);
        exp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        chk("midrst_rdy_release", in_ready, 0);
        tick();
        chk("midrst_rdy_after", in_ready, 1);

        // full-rate stream of a ramp
        out_ready = 1'b1;
        stream_capture(ramp_vec());
        drain(cyc);
        chk("stream_cycles", cyc, N);
        chk("stream_end_valid", out_valid, 0);
        chk("stream_end_ready", in_ready, 1);

        // back-pressure at index 5
        stream_capture(ramp_vec());
        cyc = 0;
        while (!(out_valid && out_index == 5) && cyc < 40) begin tick(); cyc++; end
        chk("bp_at_index5", out_index, 5);
        out_ready = 1'b0;
        repeat (3) tick();
        chk("bp_held_data", out_data, 16'h0105);
        chk("bp_held_valid", out_valid, 1);
        out_ready = 1'b1;
        drain(cyc);

        // random streams with random back-pressure
        for (int r = 0; r < 3; r++) begin
            out_ready = 1'b1;
            stream_capture(rand_vec());
            cyc = 0;
            while (exp_q.size() != 0 && cyc < 500) begin
                out_ready = ($urandom % 2) != 0;
                tick();
                cyc++;
            end
            chk("rand_stream_empty", exp_q.size(), 0);
        end
        out_ready = 1'b1;
        repeat (2) tick();

        // in_valid during a stream is ignored; later capture works
        va = rand_vec();
        vb = rand_vec();
        stream_capture(va);
        in_valid = 1'b1;
        in_data  = vb;
        mode     = 1'b1;
        repeat (8) tick();
        in_valid = 1'b0;
        drain(cyc);
        chk("ignore_rdy", in_ready, 1);
        stream_capture(vb);
        drain(cyc);

        // ACCESS: every index, latency 1
        va = rand_vec();
        out_ready = 1'b1;
        access_capture(va);
        chk("acc_in_ready_low", in_ready, 0);
        for (int k = 0; k < N; k++) begin
            sel_valid = 1'b1;
            sel = SW'(k);
            b.d = lane_of(va, k);
            b.i = SW'(k);
            b.l = 1'b0;
            exp_q.push_back(b);
            tick();
            chk("acc_lat_valid", out_valid, 1);
            chk("acc_lat_data", out_data, lane_of(va, k));
        end
        sel_valid = 1'b0;
        tick();
        pend = 1'b0;

        // ACCESS: random requests with back-pressure and hold-off
        for (int c = 0; c < 60; c++) begin
            rdy = ($urandom % 2) != 0;
            sv  = ($urandom % 4) != 0;
            s   = SW'($urandom % N);
            out_ready = rdy;
            sel_valid = sv;
            sel = s;
            taken = sv && (!pend || rdy);
            if (taken) begin
                b.d = lane_of(va, int'(s));
                b.i = s;
                b.l = 1'b0;
                exp_q.push_back(b);
            end
            pend = taken || (pend && !rdy);
            tick();
            chk("acc_valid", out_valid, pend);
        end
        rdy = ($urandom % 2) != 0;
        out_ready = rdy;
        sel_valid = 1'b1;
        done = 1'b1;
        if (pend && !rdy) void'(exp_q.pop_back());
        tick();
        done = 1'b0;
        sel_valid = 1'b0;
        chk("done_valid", out_valid, 0);
        chk("done_ready", in_ready, 1);
        chk("done_queue", exp_q.size(), 0);

        // done and sel_valid together: done wins
        out_ready = 1'b1;
        access_capture(rand_vec());
        done = 1'b1;
        sel_valid = 1'b1;
        sel = 4'd3;
        tick();
        done = 1'b0;
        sel_valid = 1'b0;
        chk("done_win_valid", out_valid, 0);
        chk("done_win_ready", in_ready, 1);
        tick();
        chk("done_win_valid2", out_valid, 0);

        // N=12 instance: out-of-range index reads zero
        for (int k = 0; k < N2; k++) v12[k*W +: W] = W'($urandom | 1);
        cyc = 0;
        while (!in_ready_b && cyc < 50) begin tick(); cyc++; end
        in_valid_b = 1'b1;
        mode_b = 1'b1;
        in_data_b = v12;
        tick();
        in_valid_b = 1'b0;
        out_ready_b = 1'b1;
        sel_valid_b = 1'b1;
        sel_b = 4'd13;
        tick();
        chk("n12_oor_valid", out_valid_b, 1);
        chk("n12_oor_data", out_data_b, 0);
        chk("n12_oor_index", out_index_b, 13);
        chk("n12_oor_last", out_last_b, 0);
        sel_b = 4'd11;
        tick();
        chk("n12_lane11_data", out_data_b, v12[11*W +: W]);
        chk("n12_lane11_index", out_index_b, 11);
        sel_b = 4'd12;
        tick();
        chk("n12_sel12_data", out_data_b, 0);
        sel_valid_b = 1'b0;
        done_b = 1'b1;
        tick();
        done_b = 1'b0;
        chk("n12_done_valid", out_valid_b, 0);
        chk("n12_done_ready", in_ready_b, 1);

        repeat (2) tick();
        chk("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
